// File: rtl/morse_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | morse_pkg                                                        |
// | Letter encodings, symbol table and FSM states for the Morse path |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package morse_pkg;

    localparam int CODE_W      = 5;
    localparam int LEN_W       = 3;
    localparam int MAX_SYMBOLS = 4;
    localparam int SYM_IDX_W   = $clog2(MAX_SYMBOLS);
    localparam int NUM_LETTERS = 8;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } morse_sym_t;

    // Indexed by letter_t; len is symbol count minus 1, bit i of code is symbol i (1 = dash)
    localparam morse_sym_t MORSE_TABLE [NUM_LETTERS] = '{
        '{3'd1, 5'b00010},
        '{3'd3, 5'b00001},
        '{3'd3, 5'b00101},
        '{3'd2, 5'b00001},
        '{3'd0, 5'b00000},
        '{3'd3, 5'b00100},
        '{3'd2, 5'b00011},
        '{3'd3, 5'b00000}
    };

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MARK  = 2'd2,
        ST_SPACE = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/morse_decode_lut.sv
`default_nettype none
// +------------------------------------------------------------------+
// | morse_decode_lut                                                 |
// | Combinational (len, code) -> letter lookup with hit flag         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module morse_decode_lut
    import morse_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic [LEN_W-1:0]  len_i,
    output letter_t           letter_o,
    output logic              hit_o
);

    always_comb begin
        letter_o = LTR_A;
        hit_o    = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (MORSE_TABLE[i] == {len_i, code_i}) begin
                hit_o    = 1'b1;
                letter_o = letter_t'(i[2:0]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_rx_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | morse_rx_decoder                                                 |
// | Times a keyed line into dots/dashes and decodes letters A..H     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int DASH_UNITS     = 2,
    parameter int GAP_UNITS      = 2,
    parameter int MAX_MARK_UNITS = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_i,
    output logic [2:0]        letter_o,
    output logic [CODE_W-1:0] code_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int DASH_CYC = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_CYC  = GAP_UNITS * UNIT_CYCLES;
    localparam int MAXM_CYC = MAX_MARK_UNITS * UNIT_CYCLES;
    localparam int CNT_MAX  = (MAXM_CYC > GAP_CYC) ? MAXM_CYC : GAP_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] MAXM_C   = CNT_W'(MAXM_CYC);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(2);
    localparam logic [LEN_W-1:0] SYM_LIM  = LEN_W'(MAX_SYMBOLS);
    localparam logic [LEN_W-1:0] SYM_SAT  = LEN_W'(MAX_SYMBOLS + 1);

    logic                   sync1_q;
    logic                   key_s_q;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       mark_cnt_q, mark_cnt_d;
    logic [CNT_W-1:0]       space_cnt_q, space_cnt_d;
    logic [LEN_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic [MAX_SYMBOLS-1:0] sym_q, sym_d;
    logic                   long_q, long_d;
    logic                   ovf_q, ovf_d;
    letter_t                letter_q, letter_d;
    logic [CODE_W-1:0]      code_q, code_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic [CODE_W-1:0]      cap_code;
    logic [LEN_W-1:0]       cap_len;
    letter_t                lut_letter;
    logic                   lut_hit;

    assign cap_code = {{(CODE_W-MAX_SYMBOLS){1'b0}}, sym_q};
    assign cap_len  = sym_cnt_q - LEN_W'(1);

    morse_decode_lut u_lut (
        .code_i   (cap_code),
        .len_i    (cap_len),
        .letter_o (lut_letter),
        .hit_o    (lut_hit)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            key_s_q     <= 1'b0;
            state_q     <= ST_ARM;
            mark_cnt_q  <= '0;
            space_cnt_q <= '0;
            sym_cnt_q   <= '0;
            sym_q       <= '0;
            long_q      <= 1'b0;
            ovf_q       <= 1'b0;
            letter_q    <= LTR_A;
            code_q      <= '0;
            len_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= key_i;
            key_s_q     <= sync1_q;
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            space_cnt_q <= space_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            sym_q       <= sym_d;
            long_q      <= long_d;
            ovf_q       <= ovf_d;
            letter_q    <= letter_d;
            code_q      <= code_d;
            len_q       <= len_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mark_cnt_d  = mark_cnt_q;
        space_cnt_d = space_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        sym_d       = sym_q;
        long_d      = long_q;
        ovf_d       = ovf_q;
        letter_d    = letter_q;
        code_d      = code_q;
        len_d       = len_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_ARM: begin
                // Synchroniser flops restart at 0, so let real samples flush through
                // before trusting key_s; a key held across reset then stays ignored.
                if (mark_cnt_q < SETTLE_C) begin
                    mark_cnt_d = mark_cnt_q + CNT_W'(1);
                end else if (!key_s_q) begin
                    state_d    = ST_IDLE;
                    mark_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (key_s_q) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = CNT_W'(1);
                    sym_cnt_d  = '0;
                    sym_d      = '0;
                    long_d     = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            ST_MARK: begin
                if (key_s_q) begin
                    if (mark_cnt_q != MAXM_C) begin
                        mark_cnt_d = mark_cnt_q + CNT_W'(1);
                    end
                    if (mark_cnt_q >= MAXM_C - CNT_W'(1)) begin
                        long_d = 1'b1;
                    end
                end else begin
                    if (sym_cnt_q < SYM_LIM) begin
                        sym_d[sym_cnt_q[SYM_IDX_W-1:0]] = (mark_cnt_q >= DASH_C);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (sym_cnt_q != SYM_SAT) begin
                        sym_cnt_d = sym_cnt_q + LEN_W'(1);
                    end
                    state_d     = ST_SPACE;
                    space_cnt_d = CNT_W'(1);
                end
            end
            ST_SPACE: begin
                if (space_cnt_q >= GAP_C) begin
                    state_d = ST_IDLE;
                    code_d  = cap_code;
                    len_d   = cap_len;
                    if (lut_hit && !long_q && !ovf_q) begin
                        valid_d  = 1'b1;
                        letter_d = lut_letter;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (key_s_q) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = CNT_W'(1);
                end else begin
                    space_cnt_d = space_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign letter_o = letter_q;
    assign code_o   = code_q;
    assign len_o    = len_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q == ST_MARK) || (state_q == ST_SPACE);

endmodule
`default_nettype wire

// File: tb/tb_morse_rx_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_morse_rx_decoder                                              |
// | Directed stimulus with a scoreboard of expected letter results   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_morse_rx_decoder;

    localparam int LATENCY = 11;

    logic       clk;
    logic       rst_ni;
    logic       key_i;
    logic [2:0] letter_o;
    logic [4:0] code_o;
    logic [2:0] len_o;
    logic       valid_o;
    logic       err_o;
    logic       busy_o;

    typedef struct {
        bit         is_valid;
        logic [2:0] letter;
        logic [4:0] code;
        logic [2:0] len;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         cyc        = 0;
    int         last_fall  = 0;
    logic [2:0] model_letter = 3'd0;

    morse_rx_decoder dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .key_i    (key_i),
        .letter_o (letter_o),
        .code_o   (code_o),
        .len_o    (len_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .busy_o   (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge where the key falls.
    task automatic mark(input int n);
        key_i = 1'b1;
        repeat (n) @(negedge clk);
        key_i = 1'b0;
        last_fall = cyc;
    endtask

    task automatic low(input int n);
        key_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int nsym, input logic [4:0] pattern, input int sp);
        for (int i = 0; i < nsym; i++) begin
            mark(pattern[i] ? 12 : 4);
            if (i != nsym - 1) low(sp);
        end
    endtask

    task automatic push(input bit is_valid, input logic [2:0] letter,
                        input logic [4:0] code, input logic [2:0] len);
        exp_t e;
        if (is_valid) model_letter = letter;
        e.is_valid = is_valid;
        e.letter   = model_letter;
        e.code     = code;
        e.len      = len;
        e.cyc      = last_fall + LATENCY;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (valid_o || err_o) begin
            exp_t e;
            check("pulse_exclusive", {31'd0, valid_o & err_o}, 32'd0);
            check("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("valid", {31'd0, valid_o}, {31'd0, e.is_valid});
                check("err", {31'd0, err_o}, {31'd0, !e.is_valid});
                check("letter", {29'd0, letter_o}, {29'd0, e.letter});
                check("code", {27'd0, code_o}, {27'd0, e.code});
                check("len", {29'd0, len_o}, {29'd0, e.len});
                check("latency_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        key_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_letter", {29'd0, letter_o}, 32'd0);
        check("rst_code", {27'd0, code_o}, 32'd0);
        check("rst_len", {29'd0, len_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_ni = 1'b1;
        low(6);

        // A
        send(2, 5'b00010, 4);
        push(1'b1, 3'd0, 5'b00010, 3'd1);
        low(14);
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // C then E with an 8-cycle gap
        send(4, 5'b00101, 4);
        push(1'b1, 3'd2, 5'b00101, 3'd3);
        low(8);
        send(1, 5'b00000, 4);
        push(1'b1, 3'd4, 5'b00000, 3'd0);
        low(14);

        // Dot/dash threshold
        mark(7);
        push(1'b1, 3'd4, 5'b00000, 3'd0);
        low(14);
        mark(8);
        push(1'b0, 3'd0, 5'b00001, 3'd0);
        low(14);

        // Gap threshold: 7-cycle spaces keep the letter together
        send(4, 5'b00010, 7);
        push(1'b0, 3'd0, 5'b00010, 3'd3);
        low(14);
        send(4, 5'b00001, 7);
        push(1'b1, 3'd1, 5'b00001, 3'd3);
        low(14);

        // Overflow and over-long mark
        send(5, 5'b00000, 4);
        push(1'b0, 3'd0, 5'b00000, 3'd4);
        low(14);
        mark(20);
        push(1'b0, 3'd0, 5'b00001, 3'd0);
        low(14);

        // Reset in the middle of a letter
        mark(4);
        low(3);
        check("busy_in_space", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        model_letter = 3'd0;
        check("busy_after_rst", {31'd0, busy_o}, 32'd0);
        check("letter_after_rst", {29'd0, letter_o}, 32'd0);
        low(20);

        // Key held high across reset release
        rst_ni = 1'b0;
        key_i  = 1'b1;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk);
        check("held_key_busy", {31'd0, busy_o}, 32'd0);
        low(20);
        check("held_key_idle", {31'd0, busy_o}, 32'd0);
        send(1, 5'b00000, 4);
        push(1'b1, 3'd4, 5'b00000, 3'd0);
        low(14);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
